sram_mem_ctrl: RTL
==================

// Module: sram_mem_ctrl
// PURPOSE
//  Data-memory interface for the MEM stage. Replaces the single-cycle Memory model.
//  Takes the MEM stage's 32-bit load/store request (address = ALU result, store data = Rm value).
//  Executes it as two 16-bit accesses on an external asynchronous SRAM.
//  Returns the 32-bit load word; drives ready low while busy, and the top level freezes all pipeline registers on ~ready.
// PARAMETERS
//  BASE_ADDR    1024  byte address that maps to SRAM halfword 0
//  WAIT_CYCLES  2     clock cycles per 16-bit SRAM access (legal range 1..15)
// PORTS
//  clk          in   1   system clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active high
//  rd_en        in   1   load request (MEM_R_EN)
//  wr_en        in   1   store request (MEM_W_EN)
//  address      in   32  byte address from ALU result, word aligned
//  write_data   in   32  store data (Val_Rm)
//  read_data    out  32  load result; valid while ready=1 in DONE
//  ready        out  1   1 = no access in progress; 0 = pipeline must freeze
//  sram_addr    out  18  SRAM halfword address
//  sram_we_n    out  1   SRAM write strobe, active low
//  sram_dq_out  out  16  SRAM write data
//  sram_dq_oe   out  1   1 = drive sram_dq_out onto the DQ bus (top level builds the tristate)
//  sram_dq_in   in   16  SRAM read data
// BEHAVIOUR
//  FSM states: IDLE, LO, HI, DONE. A counter cnt counts 0..WAIT_CYCLES-1 within LO and HI.
//  Reset values: state=IDLE, cnt=0, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
//  Request capture:
//  - IDLE with (rd_en|wr_en): latch op, off=(address-BASE_ADDR)[18:2], and write_data; go to LO, cnt=0.
//  - If rd_en and wr_en are both 1, the access is a write.
//  Address mapping: sram_addr={off,1'b0} in LO and {off,1'b1} in HI. Bits above [18] are discarded (wrap).
//  Write phases:
//  - sram_we_n=0 and sram_dq_oe=1 for every cycle of LO and HI.
//  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
//  Read phases:
//  - sram_we_n=1, sram_dq_oe=0.
//  - read_data[15:0] <= sram_dq_in on the last LO cycle (cnt==WAIT_CYCLES-1).
//  - read_data[31:16] <= sram_dq_in on the last HI cycle.
//  Transitions:
//  - LO->HI and HI->DONE when cnt==WAIT_CYCLES-1; cnt resets to 0 on each phase change.
//  - DONE->IDLE always, after exactly 1 cycle.
//  ready rule (combinational): ready = (state==IDLE & ~rd_en & ~wr_en) | (state==DONE).
//  - ready is 0 in the IDLE cycle that accepts a request.
//  Latency: request seen in IDLE at cycle t -> ready=1 at t+2*WAIT_CYCLES+1 (WAIT_CYCLES=2: t+5).
//  - The pipeline advances on that edge.
//  - The MEM/WB register captures read_data in DONE.
//  Request inputs are stable while ready=0, because the pipeline is frozen.
//  - Changes to inputs outside IDLE are ignored; the latched copies are used.
//  In DONE, rd_en/wr_en still high belong to the departing instruction and must not re-trigger.
//  - The next request is accepted only from IDLE.
//  read_data holds its value until the next load overwrites it. Writes never modify read_data.
//  Between accesses (IDLE/DONE): sram_we_n=1, sram_dq_oe=0.
//  Reset mid-access (any state): next cycle is IDLE with reset values.
//  - An interrupted write may leave its low half written; this is not rolled back.
//  Back-to-back requests: DONE->IDLE->LO. Minimum 2*WAIT_CYCLES+2 cycles per access.
//  - The IDLE accept cycle has ready=0.
// TESTING
//  1 Reset: hold rst 2 cycles with rd_en=1 -> state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0 after release.
//  2 Store 0xDEADBEEF @1024, then load @1024:
//    - SRAM model holds 0xBEEF at halfword 0 and 0xDEAD at halfword 1.
//    - The load returns 0xDEADBEEF; ready=0 exactly 5 cycles per access (WAIT_CYCLES=2).
//  3 Address map: store 0x12345678 @1032 -> sram_addr 4 gets 0x5678 and 5 gets 0x1234; sram_we_n=0 for 4 cycles total.
//  4 rd_en=wr_en=1 @1028 with data 0x0000FFFF -> write performed to halfwords 2/3; read_data unchanged.
//  5 Assert rst during HI of a load @1040 -> IDLE next cycle, ready=1 with inputs low.
//    - A new load @1024 then completes normally.
//  6 WAIT_CYCLES=1 build: load immediately followed by store (inputs held high through DONE):
//    - Each access gives ready=0 for 3 cycles; DONE does not re-trigger; the second access starts from IDLE.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data memory controller: splits each 32-bit load/store into two
// 16-bit accesses on an external asynchronous SRAM and stalls the pipeline while busy.
module sram_mem_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] off;
    logic [31:0] wdata;
    logic [31:0] rel;
    logic        last;
    logic        req;
    logic        unused_rel_bits;

    assign rel  = address - 32'(BASE_ADDR);
    assign last = (cnt == LAST);
    assign req  = rd_en | wr_en;

    // Only rel[18:2] selects a word; higher bits wrap, low bits are alignment.
    assign unused_rel_bits = ^{rel[31:19], rel[1:0]};

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req)  next_state = LO;
            LO:   if (last) next_state = HI;
            HI:   if (last) next_state = DONE;
            DONE:           next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    always_comb begin
        ready       = ((state == IDLE) && !req) || (state == DONE);
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        case (state)
            LO: begin
                sram_addr = {off, 1'b0};
                if (op_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata[15:0];
                end
            end
            HI: begin
                sram_addr = {off, 1'b1};
                if (op_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata[31:16];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            off       <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= '0;
            else if (state == LO || state == HI)
                cnt <= cnt + 4'd1;

            if (state == IDLE && req) begin
                op_wr <= wr_en;
                off   <= rel[18:2];
                wdata <= write_data;
            end

            // The SRAM output has settled by the final wait cycle of each phase.
            if (!op_wr && last) begin
                if (state == LO) read_data[15:0]  <= sram_dq_in;
                if (state == HI) read_data[31:16] <= sram_dq_in;
            end
        end
    end

endmodule
